// File: rtl/sync_ram_req_ctrl.sv
// sync_ram_req_ctrl: valid/ready request front-end for a 16x16 synchronous RAM with a backpressured read response channel.
// Define RAM_CTRL_CLEAR_EN to zero the whole RAM in a sweep after every reset.
module sync_ram_req_ctrl #(
    parameter int DW = 16,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          ram_we,
    output logic          ram_re,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout,
    output logic          busy
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RD_WAIT = 2'd1;
    localparam logic [1:0] RSP     = 2'd2;
`ifdef RAM_CTRL_CLEAR_EN
    localparam int         DEPTH       = 2 ** AW;
    localparam logic [1:0] CLEAR       = 2'd3;
    localparam logic [1:0] RESET_STATE = CLEAR;
`else
    localparam logic [1:0] RESET_STATE = IDLE;
`endif

    logic [1:0]    state_q, state_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
    logic          accept;
`ifdef RAM_CTRL_CLEAR_EN
    logic [AW-1:0] clr_cnt_q, clr_cnt_d;
`endif

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign accept    = req_valid & req_ready;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

    always_comb begin
        state_d     = state_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        ram_we      = 1'b0;
        ram_re      = 1'b0;
        ram_addr    = '0;
        ram_din     = '0;
`ifdef RAM_CTRL_CLEAR_EN
        clr_cnt_d   = clr_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                ram_we   = accept & req_we;
                ram_re   = accept & ~req_we;
                ram_addr = req_addr;
                ram_din  = req_wdata;
                if (accept && !req_we) begin
                    state_d = RD_WAIT;
                end
            end
            // The RAM presents its registered read word during this cycle.
            RD_WAIT: begin
                rsp_rdata_d = ram_dout;
                rsp_valid_d = 1'b1;
                state_d     = RSP;
            end
            RSP: begin
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
`ifdef RAM_CTRL_CLEAR_EN
            CLEAR: begin
                ram_we    = 1'b1;
                ram_addr  = clr_cnt_q;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == AW'(DEPTH - 1)) begin
                    state_d = IDLE;
                end
            end
`endif
            default: begin
                state_d = RESET_STATE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RESET_STATE;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef RAM_CTRL_CLEAR_EN
            clr_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
`ifdef RAM_CTRL_CLEAR_EN
            clr_cnt_q   <= clr_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_sync_ram_req_ctrl.sv
// tb_sync_ram_req_ctrl: drives sync_ram_req_ctrl against a behavioural RAM, checking
// responses against an expected-contents array (honours RAM_CTRL_CLEAR_EN).
module tb_sync_ram_req_ctrl;
    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          ram_we;
    logic          ram_re;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout = '0;
    logic          busy;

    logic [DW-1:0] ram_mem [DEPTH];
    logic [DW-1:0] exp_mem [DEPTH];
    bit            known   [DEPTH];
    int            vectors = 0;
    int            miscompares = 0;

    sync_ram_req_ctrl #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .ram_we(ram_we), .ram_re(ram_re), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout), .busy(busy)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: write and registered read both act on the rising edge.
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_din;
        if (ram_re) ram_dout <= ram_mem[ram_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic check_sweep();
`ifdef RAM_CTRL_CLEAR_EN
        for (int i = 0; i < DEPTH; i++) begin
            vectors++;
            if (busy !== 1'b1 || req_ready !== 1'b0 || ram_we !== 1'b1 || ram_re !== 1'b0 || ram_addr !== AW'(i) || ram_din !== 16'h0000) begin
                miscompares++;
                $display("[TB] FAIL sweep_%0d: got busy=%b rdy=%b we=%b re=%b addr=%h din=%h, expected busy=1 rdy=0 we=1 re=0 addr=%h din=0000", i, busy, req_ready, ram_we, ram_re, ram_addr, ram_din, AW'(i));
            end
            tick();
        end
        vectors++;
        if (busy !== 1'b0 || req_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL sweep_end: got busy=%b rdy=%b, expected busy=0 rdy=1", busy, req_ready);
        end
        for (int i = 0; i < DEPTH; i++) begin
            exp_mem[i] = '0;
            known[i]   = 1'b1;
        end
`endif
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
        #1;
        vectors++;
        if (req_ready !== 1'b1 || ram_we !== 1'b1 || ram_re !== 1'b0 || ram_addr !== a || ram_din !== d) begin
            miscompares++;
            $display("[TB] FAIL wr_issue: got rdy=%b we=%b re=%b addr=%h din=%h, expected rdy=1 we=1 re=0 addr=%h din=%h", req_ready, ram_we, ram_re, ram_addr, ram_din, a, d);
        end
        tick();
        exp_mem[a] = d;
        known[a]   = 1'b1;
        req_valid  = 1'b0;
        #1;
        vectors++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL wr_no_rsp: got rsp_valid=%b busy=%b, expected 0 0", rsp_valid, busy);
        end
    endtask

    task automatic do_read(input logic [AW-1:0] a, input int hold, input bit conc,
                           input logic [AW-1:0] ca, input logic [DW-1:0] cd);
        logic [DW-1:0] exp_d;
        exp_d = exp_mem[a];
        req_valid = 1'b1; req_we = 1'b0; req_addr = a; rsp_ready = 1'b0;
        #1;
        vectors++;
        if (req_ready !== 1'b1 || ram_re !== 1'b1 || ram_we !== 1'b0 || ram_addr !== a) begin
            miscompares++;
            $display("[TB] FAIL rd_issue: got rdy=%b re=%b we=%b addr=%h, expected rdy=1 re=1 we=0 addr=%h", req_ready, ram_re, ram_we, ram_addr, a);
        end
        tick();
        req_valid = 1'b0;
        #1;
        vectors++;
        if (rsp_valid !== 1'b0 || busy !== 1'b1 || req_ready !== 1'b0 || ram_re !== 1'b0 || ram_we !== 1'b0 || ram_addr !== 4'h0) begin
            miscompares++;
            $display("[TB] FAIL rd_wait: got vld=%b busy=%b rdy=%b re=%b we=%b addr=%h, expected 0 1 0 0 0 0", rsp_valid, busy, req_ready, ram_re, ram_we, ram_addr);
        end
        if (conc) begin
            req_valid = 1'b1; req_we = 1'b1; req_addr = ca; req_wdata = cd;
        end
        tick();
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== exp_d) begin
            miscompares++;
            $display("[TB] FAIL rd_data@%h: got vld=%b data=%h, expected vld=1 data=%h", a, rsp_valid, rsp_rdata, exp_d);
        end
        for (int h = 0; h < hold; h++) begin
            vectors++;
            if (req_ready !== 1'b0 || ram_we !== 1'b0 || ram_re !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL rd_block: got rdy=%b we=%b re=%b, expected 0 0 0", req_ready, ram_we, ram_re);
            end
            tick();
            vectors++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== exp_d) begin
                miscompares++;
                $display("[TB] FAIL rd_hold: got vld=%b data=%h, expected vld=1 data=%h", rsp_valid, rsp_rdata, exp_d);
            end
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        vectors++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL rd_release: got vld=%b rdy=%b, expected vld=0 rdy=1", rsp_valid, req_ready);
        end
        if (conc) begin
            vectors++;
            if (ram_we !== 1'b1 || ram_addr !== ca || ram_din !== cd) begin
                miscompares++;
                $display("[TB] FAIL held_wr: got we=%b addr=%h din=%h, expected we=1 addr=%h din=%h", ram_we, ram_addr, ram_din, ca, cd);
            end
            tick();
            exp_mem[ca] = cd;
            known[ca]   = 1'b1;
            req_valid   = 1'b0;
            #1;
        end
    endtask

    task automatic test_reset();
        do_reset(2);
        vectors++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 16'h0000) begin
            miscompares++;
            $display("[TB] FAIL reset_rsp: got vld=%b data=%h, expected vld=0 data=0000", rsp_valid, rsp_rdata);
        end
`ifdef RAM_CTRL_CLEAR_EN
        check_sweep();
`else
        vectors++;
        if (busy !== 1'b0 || req_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_idle: got busy=%b rdy=%b, expected busy=0 rdy=1", busy, req_ready);
        end
`endif
    endtask

    task automatic test_write_read();
        do_write(4'd0, 16'hA5A5);
        do_write(4'd1, 16'h1234);
        do_write(4'd2, 16'hFFFF);
        do_read(4'd0, 0, 1'b0, 4'd0, 16'h0);
        do_read(4'd1, 0, 1'b0, 4'd0, 16'h0);
        do_read(4'd2, 0, 1'b0, 4'd0, 16'h0);
    endtask

    task automatic test_backpressure();
        do_read(4'd1, 5, 1'b1, 4'd1, 16'h0000);
        do_read(4'd1, 0, 1'b0, 4'd0, 16'h0);
    endtask

    task automatic test_boundary();
        do_write(4'd15, 16'h0F0F);
        do_read(4'd15, 1, 1'b0, 4'd0, 16'h0);
    endtask

    task automatic test_reset_mid_read();
        req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd15; rsp_ready = 1'b0;
        tick();
        req_valid = 1'b0;
        tick();
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== exp_mem[15]) begin
            miscompares++;
            $display("[TB] FAIL pre_rst_rsp: got vld=%b data=%h, expected vld=1 data=%h", rsp_valid, rsp_rdata, exp_mem[15]);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        vectors++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 16'h0000) begin
            miscompares++;
            $display("[TB] FAIL rst_in_rsp: got vld=%b data=%h, expected vld=0 data=0000", rsp_valid, rsp_rdata);
        end
        check_sweep();
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL stale_rsp: got vld=%b busy=%b, expected 0 0", rsp_valid, busy);
            end
            tick();
        end
        rsp_ready = 1'b0;
        do_read(4'd15, 0, 1'b0, 4'd0, 16'h0);
    endtask

`ifdef RAM_CTRL_CLEAR_EN
    task automatic test_clear();
        do_write(4'd2, 16'hBEEF);
        do_reset(2);
        repeat (5) tick();
        do_reset(1);
        check_sweep();
        do_read(4'd2, 0, 1'b0, 4'd0, 16'h0);
    endtask
`endif

    task automatic test_random();
        logic [AW-1:0] a;
        int            k;
        for (int n = 0; n < 80; n++) begin
            a = AW'($urandom_range(0, DEPTH - 1));
            k = -1;
            for (int j = 0; j < DEPTH; j++) begin
                if (k < 0 && known[(int'(a) + j) % DEPTH]) k = (int'(a) + j) % DEPTH;
            end
            if ($urandom_range(0, 2) == 0 || k < 0) begin
                do_write(a, DW'($urandom));
            end else begin
                do_read(AW'(k), $urandom_range(0, 3), ($urandom_range(0, 3) == 0),
                        AW'($urandom_range(0, DEPTH - 1)), DW'($urandom));
            end
            if ($urandom_range(0, 4) == 0) begin
                tick();
                vectors++;
                if (ram_we !== 1'b0 || ram_re !== 1'b0 || rsp_valid !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL idle_gap: got we=%b re=%b vld=%b, expected 0 0 0", ram_we, ram_re, rsp_valid);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
        test_reset();
        test_write_read();
        test_backpressure();
        test_boundary();
        test_reset_mid_read();
`ifdef RAM_CTRL_CLEAR_EN
        test_clear();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
